// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, responder FSM state types and address-range helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_COLLECT,
    W_COMMIT,
    W_RESP,
    W_STALL
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RESP,
    R_STALL
  } r_state_e;

  // Any address bit above the word-index field marks the access as out of range.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned mem_aw);
    return (addr >> (mem_aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/axi_lite_bram.sv
// Single-clock byte-enable RAM: one write port, one read port, registered read data.
module axi_lite_bram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Array contents are never reset; only the read register is, so rdata is 0 in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite memory responder with independent write/read FSMs and optional post-response stall.
module axi_lite_mem_responder
  import axi_lite_pkg::*;
#(
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic        i_controller_clk,
  input  logic        i_rst_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [15:0] o_wr_count,
  output logic [15:0] o_rd_count
);

  localparam int unsigned    SCW        = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [SCW-1:0] STALL_LOAD = SCW'(STALL_CYCLES);

  logic           active_q;
  w_state_e       w_state_q, w_collect_d;
  logic           aw_held_q, w_held_q, aw_held_d, w_held_d;
  logic [31:0]    awaddr_q, wdata_q;
  logic [3:0]     wstrb_q;
  logic [SCW-1:0] wstall_q;
  logic           bvalid_q;
  logic [1:0]     bresp_q;
  logic [15:0]    wr_count_q;
  r_state_e       r_state_q;
  logic [SCW-1:0] rstall_q;
  logic           rvalid_q, rd_oor_q;
  logic [1:0]     rresp_q;
  logic [15:0]    rd_count_q;
  logic           aw_fire, w_fire, ar_fire, aw_oor, ar_oor, mem_we;
  logic [31:0]    mem_rdata;
  logic           unused_awprot;

  assign unused_awprot = ^s_axi_awprot;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end

  assign s_axi_awready = active_q && !aw_held_q && (w_state_q != W_RESP) &&
                         (w_state_q != W_COMMIT) && (wstall_q == '0);
  assign s_axi_wready  = active_q && !w_held_q && (w_state_q != W_RESP) &&
                         (w_state_q != W_COMMIT);
  assign s_axi_arready = active_q && (r_state_q != R_RESP) && (rstall_q == '0);

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign aw_oor  = addr_oor(awaddr_q, MEM_AW);
  assign ar_oor  = addr_oor(s_axi_araddr, MEM_AW);
  assign mem_we  = (w_state_q == W_COMMIT) && !aw_oor && (wstrb_q != '0);

  always_comb begin
    aw_held_d = aw_held_q | aw_fire;
    w_held_d  = w_held_q | w_fire;
    if (aw_held_d && w_held_d)      w_collect_d = W_COMMIT;
    else if (aw_held_d || w_held_d) w_collect_d = W_COLLECT;
    else                            w_collect_d = W_IDLE;
  end

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wstall_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_count_q <= '0;
    end else begin
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi_awaddr;
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi_wdata;
        wstrb_q  <= s_axi_wstrb;
      end
      unique case (w_state_q)
        W_IDLE, W_COLLECT: w_state_q <= w_collect_d;
        W_COMMIT: begin
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
          w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            if (wr_count_q != '1) wr_count_q <= wr_count_q + 16'd1;
            wstall_q  <= STALL_LOAD;
            w_state_q <= (STALL_CYCLES == 0) ? W_IDLE : W_STALL;
          end
        end
        // W may be accepted during the stall, so leave via the collect decision.
        W_STALL: begin
          if (wstall_q > SCW'(1)) begin
            wstall_q <= wstall_q - SCW'(1);
          end else begin
            wstall_q  <= '0;
            w_state_q <= w_collect_d;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state_q  <= R_IDLE;
      rstall_q   <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rd_oor_q   <= 1'b0;
      rd_count_q <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            rvalid_q  <= 1'b1;
            rresp_q   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            rd_oor_q  <= ar_oor;
            r_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            if (rd_count_q != '1) rd_count_q <= rd_count_q + 16'd1;
            rstall_q  <= STALL_LOAD;
            r_state_q <= (STALL_CYCLES == 0) ? R_IDLE : R_STALL;
          end
        end
        R_STALL: begin
          if (rstall_q > SCW'(1)) begin
            rstall_q <= rstall_q - SCW'(1);
          end else begin
            rstall_q  <= '0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  axi_lite_bram #(.AW(MEM_AW)) u_bram (
    .clk_i   (i_controller_clk),
    .rst_ni  (i_rst_n),
    .we_i    (mem_we),
    .be_i    (wstrb_q),
    .waddr_i (awaddr_q[MEM_AW+1:2]),
    .wdata_i (wdata_q),
    .re_i    (ar_fire),
    .raddr_i (s_axi_araddr[MEM_AW+1:2]),
    .rdata_o (mem_rdata)
  );

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rd_oor_q ? '0 : mem_rdata;
  assign o_wr_count   = wr_count_q;
  assign o_rd_count   = rd_count_q;

endmodule
